// File: rtl/key_debounce_irq.sv
// rtl/key_debounce_irq.sv - per-key push-button debouncer with press/release pulses and maskable pending interrupt
// Each key: 2-flop synchronizer, 4-state qualification FSM, and a sticky pending bit that feeds a level irq.
module key_debounce_irq #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                CLOCK2_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_KEYS-1:0] irq_mask,
  input  logic [NUM_KEYS-1:0] irq_ack,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] irq_pending,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {UP, WAIT_DOWN, DOWN, WAIT_UP} state_t;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("key_debounce_irq: DEBOUNCE_CYCLES must be at least 2");
  end
  if (NUM_KEYS < 1 || NUM_KEYS > 8) begin : g_bad_keys
    $error("key_debounce_irq: NUM_KEYS must be in 1..8");
  end

  // Synchronizer resets to released so a held key requalifies after reset.
  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;

  always_ff @(posedge CLOCK2_50) begin
    if (RESET) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          press_nxt, release_nxt;
    logic          press_q, release_q;
    logic          pressed;

    assign pressed = ~key_sync[i];

    always_ff @(posedge CLOCK2_50) begin
      if (RESET) begin
        state     <= UP;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
      end
    end

    // The counter stops at CNT_LAST because the FSM leaves the wait state there.
    always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
        UP: begin
          if (pressed) begin
            state_nxt = WAIT_DOWN;
            cnt_nxt   = '0;
          end
        end
        WAIT_DOWN: begin
          if (!pressed) begin
            state_nxt = UP;
          end else if (cnt == CNT_LAST) begin
            state_nxt = DOWN;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!pressed) begin
            state_nxt = WAIT_UP;
            cnt_nxt   = '0;
          end
        end
        WAIT_UP: begin
          if (pressed) begin
            state_nxt = DOWN;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = UP;
            release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = UP;
      endcase
    end

    assign key_level[i]   = (state == DOWN) || (state == WAIT_UP);
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
  end

  // A new press outranks an acknowledge landing in the same cycle.
  always_ff @(posedge CLOCK2_50) begin
    if (RESET) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~irq_ack) | key_press;
    end
  end

  assign irq = |(irq_pending & irq_mask);

endmodule

// File: tb/tb_key_debounce_irq.sv
// tb/tb_key_debounce_irq.sv - directed self-checking bench for key_debounce_irq
module tb_key_debounce_irq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] irq_mask;
  logic [3:0] irq_ack;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] irq_pending;
  logic       irq;

  int tests    = 0;
  int failures = 0;
  logic seen;

  key_debounce_irq #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK2_50   (clk),
    .RESET       (rst),
    .KEY         (key),
    .irq_mask    (irq_mask),
    .irq_ack     (irq_ack),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .irq_pending (irq_pending),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n cycles, remembering whether any press/release pulse appeared.
  task automatic step_watch(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      if (key_press != 4'b0 || key_release != 4'b0) seen = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    key      = 4'hF;
    irq_mask = 4'h0;
    irq_ack  = 4'h0;
    repeat (3) step();
    check("reset_outputs", {key_level, key_press, key_release, irq_pending, 3'b0, irq}, 32'h0);
    rst = 1'b0;
    step();
    check("post_reset_outputs", {key_level, key_press, key_release, irq_pending, 3'b0, irq}, 32'h0);

    // Clean press of KEY[0]: pulse after edge t+6, then 20-cycle hold and release.
    key[0] = 1'b0;
    seen = 1'b0;
    step_watch(6);
    check("press0_no_early_pulse", seen, 1'b0);
    step();
    check("press0_pulse", key_press, 4'b0001);
    check("press0_level", key_level, 4'b0001);
    step();
    check("press0_pulse_one_cycle", key_press, 4'b0000);
    check("press0_pending_masked", irq_pending, 4'b0001);
    check("press0_irq_masked", irq, 1'b0);
    irq_mask = 4'b0001;
    #1;
    check("mask_enable_irq_same_cycle", irq, 1'b1);
    irq_mask = 4'b0000;
    irq_ack  = 4'b0001;
    step();
    irq_ack = 4'b0000;
    check("press0_ack_clears", irq_pending, 4'b0000);
    repeat (11) step();
    key[0] = 1'b1;
    seen = 1'b0;
    step_watch(6);
    check("release0_no_early_pulse", seen, 1'b0);
    check("release0_level_held", key_level, 4'b0001);
    step();
    check("release0_pulse", key_release, 4'b0001);
    check("release0_level", key_level, 4'b0000);
    step();
    check("release0_pulse_one_cycle", key_release, 4'b0000);

    // Bounce on KEY[1]: toggling never qualifies, then a stable hold does.
    seen = 1'b0;
    for (int b = 0; b < 4; b++) begin
      key[1] = 1'b0;
      step_watch(2);
      key[1] = 1'b1;
      step_watch(2);
    end
    check("bounce1_no_pulse", seen, 1'b0);
    key[1] = 1'b0;
    step_watch(6);
    check("bounce1_no_early_pulse", seen, 1'b0);
    step();
    check("bounce1_press", key_press, 4'b0010);
    irq_ack = 4'b1000;
    step();
    irq_ack = 4'b0000;
    check("ack_nonpending_no_effect", irq_pending, 4'b0010);
    irq_ack = 4'b0010;
    step();
    irq_ack = 4'b0000;
    check("bounce1_ack", irq_pending, 4'b0000);
    key[1] = 1'b1;
    repeat (10) step();

    // Interrupt handshake on KEY[2].
    irq_mask = 4'b0100;
    key[2] = 1'b0;
    for (int n = 0; n < 20 && irq !== 1'b1; n++) step();
    check("handshake_irq_rises", irq, 1'b1);
    check("handshake_pending", irq_pending, 4'b0100);
    irq_ack = 4'b0100;
    step();
    irq_ack = 4'b0000;
    check("handshake_pending_cleared", irq_pending, 4'b0000);
    check("handshake_irq_cleared", irq, 1'b0);
    key[2] = 1'b1;
    irq_mask = 4'b0000;
    repeat (10) step();

    // Ack in the same cycle as key_press[3]: set wins.
    key[3] = 1'b0;
    repeat (6) step();
    check("collision_no_early_pulse", key_press, 4'b0000);
    step();
    check("collision_press", key_press, 4'b1000);
    irq_ack = 4'b1000;
    step();
    irq_ack = 4'b0000;
    check("collision_set_wins", irq_pending, 4'b1000);
    key[3] = 1'b1;
    repeat (10) step();

    // Reset during the second qualification cycle of a KEY[0] press.
    key[0] = 1'b0;
    seen = 1'b0;
    step_watch(4);
    rst = 1'b1;
    step_watch(1);
    check("midreset_outputs", {key_level, irq_pending, 3'b0, irq}, 32'h0);
    rst = 1'b0;
    step_watch(6);
    check("midreset_no_pulse", seen, 1'b0);
    step();
    check("midreset_fresh_press", key_press, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/key_debounce_irq.md
KEY_DEBOUNCE_IRQ -- requirements
Module: key_debounce_irq

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent push-button channels, legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-input count required to accept a level change, which is 20 ms at 50 MHz; values below 2 SHALL fail elaboration.
REQ-003 CLOCK2_50  input  1  sole clock; all flops SHALL be clocked on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 KEY  input  NUM_KEYS  raw, asynchronous, active-low buttons, where 0 means pressed.
REQ-006 irq_mask  input  NUM_KEYS  per-key interrupt enable, where 1 means enabled.
REQ-007 irq_ack  input  NUM_KEYS  per-key single-cycle clear of the pending bit.
REQ-008 key_level  output  NUM_KEYS  debounced state, where 1 means pressed (active-high).
REQ-009 key_press  output  NUM_KEYS  one-cycle pulse on an accepted press.
REQ-010 key_release  output  NUM_KEYS  one-cycle pulse on an accepted release.
REQ-011 irq_pending  output  NUM_KEYS  latched press events awaiting acknowledge.
REQ-012 irq  output  1  level interrupt to the Nios PIO interrupt input, equal to the OR-reduction of (irq_pending AND irq_mask).

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer before any other logic; no logic SHALL be placed between the two flops.
REQ-014 Each key SHALL have its own FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP, plus its own counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 In UP, a synchronized pressed input SHALL move the FSM to WAIT_DOWN and clear the counter; otherwise the FSM SHALL stay in UP.
REQ-016 WAIT_DOWN transitions:
- If the synchronized input returns to released, the FSM SHALL go to UP; this glitch SHALL produce no pulse.
- Otherwise the counter SHALL increment; when the counter equals DEBOUNCE_CYCLES-1, the FSM SHALL go to DOWN and assert key_press for exactly one cycle.
REQ-017 DOWN and WAIT_UP SHALL mirror REQ-015 and REQ-016 with polarity inverted, and SHALL produce a key_release pulse on entry to UP.
REQ-018 key_level SHALL be 1 exactly while the FSM is in DOWN or WAIT_UP.
REQ-019 Latency: for a raw press first sampled at edge t and held stable, the key_press pulse SHALL be high in the cycle after edge t+DEBOUNCE_CYCLES+2; release latency SHALL be identical.
REQ-020 A bounce of any length shorter than DEBOUNCE_CYCLES SHALL restart qualification, and the counter SHALL never wrap.
REQ-021 irq_pending[i] SHALL be set on key_press[i] and cleared on irq_ack[i]; if both occur in the same cycle, the set SHALL win.
REQ-022 irq_ack on a bit that is not pending SHALL have no effect.
REQ-023 irq_mask SHALL gate only irq; masked keys SHALL still set irq_pending.
REQ-024 irq SHALL be combinational from registered irq_pending and the irq_mask input, with no added latency.
REQ-025 Channels SHALL be fully independent; simultaneous presses on several keys SHALL each pulse in the same cycle.

Reset
REQ-026 While RESET=1 at a clock edge:
- Synchronizer flops SHALL load 1 (released).
- All FSMs SHALL go to UP.
- All counters SHALL load 0.
- irq_pending SHALL load 0.
REQ-027 Outputs during and immediately after reset: key_level=0, key_press=0, key_release=0, irq_pending=0, irq=0.
REQ-028 Reset asserted mid-qualification SHALL discard the partial count and emit no pulse.
REQ-029 A key held through reset release SHALL be qualified as a fresh press with REQ-019 latency.

Verification
REQ-030 All scenarios SHALL run with DEBOUNCE_CYCLES=4 and NUM_KEYS=4.
REQ-031 Clean press and release:
- Stimulus: KEY[0]=0 from edge 10 for 20 cycles, then back to 1.
- Required response: key_press[0] pulses once after edge 16; key_level[0] goes high; key_release[0] pulses once after edge 36.
REQ-032 Bounce rejection:
- Stimulus: KEY[1] toggles 0/1 every 2 cycles for 16 cycles, then holds 0.
- Required response: no pulse during the toggling; exactly one key_press[1], 6 cycles after the hold begins.
REQ-033 Interrupt handshake:
- Stimulus: press KEY[2] with irq_mask=4'b0100; after irq rises, pulse irq_ack[2].
- Required response: irq_pending=4'b0100 and irq=1, then both 0 in the cycle after the ack.
REQ-034 Set/ack collision:
- Stimulus: irq_ack[3] asserted in the same cycle as key_press[3].
- Required response: irq_pending[3]=1 afterwards.
REQ-035 Masking:
- Stimulus: irq_mask=0, press KEY[0].
- Required response: irq_pending[0]=1 and irq=0; setting irq_mask[0]=1 drives irq=1 in the same cycle.
REQ-036 Reset mid-operation:
- Stimulus: assert RESET for 1 cycle at the second qualification cycle of a KEY[0] press, while KEY stays at 0.
- Required response: no pulse before reset; key_press[0] pulses 6 cycles after RESET deasserts.
